// File: rtl/seq_detect_pkg.sv
// Shared definitions for the sequence-detector slice.
//   ser_state_t      : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_IDLE_BIT : value on the serial line when no word is in flight
//   PATTERN_WIDTH    : pattern width shared with the downstream detector
package seq_detect_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic DEFAULT_IDLE_BIT = 1'b0;
  localparam int   PATTERN_WIDTH    = 2;

endpackage

// File: rtl/word_hold_reg.sv
// One-word holding buffer with a full flag. It lets the next word be
// accepted while the current one is still being shifted out.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   load       : capture d and mark the buffer full
//   drain      : the buffered word has been consumed; clear full
//   d, q       : WIDTH-bit data in / buffered data out
//   full       : buffer holds a word
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the data word is reset too so it reads zero
  // after reset instead of a stale word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the sequence detectors. Accepts WIDTH-bit
// words over valid/ready and emits one bit per clock; a one-word holding
// buffer lets consecutive words stream without an idle bit in between.
// bit_out is meant to drive state_machine_mealy.in on the same clk/reset.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   din, din_valid      : parallel word and its valid
//   din_ready           : a word can be accepted this cycle (registered state only)
//   bit_out, bit_valid  : serial bit and its qualifier
//   last                : bit_out is the final bit of the current word
module seq_bit_serializer
  import seq_detect_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic             hold_load, hold_drain;
  logic             transfer, at_last;

  // Ready depends only on the hold flag, so there is no path from din_valid.
  assign din_ready = !hold_full;
  assign transfer  = din_valid && din_ready;
  assign at_last   = (cnt_q == CNT_LAST);

  // Move the next bit toward the output end.
  assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .drain (hold_drain),
    .d     (din),
    .q     (hold_q),
    .full  (hold_full)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          sh_d    = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          sh_d      = sh_shifted;
          cnt_d     = cnt_q + CNT_W'(1);
          hold_load = transfer;
        end else if (hold_full) begin
          // A held word always wins; ready is low, so no transfer can collide.
          sh_d       = hold_q;
          cnt_d      = '0;
          hold_drain = 1'b1;
        end else if (transfer) begin
          // Hold empty: bypass the incoming word straight into the shifter.
          sh_d  = din;
          cnt_d = '0;
        end else begin
          // Explicit clear: the counter never wraps for non-power-of-two WIDTH.
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_valid = (state_q == SHIFT);
  assign bit_out   = bit_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign last      = bit_valid && at_last;

endmodule
